// File: rtl/tx_ramp_sequencer.sv
// TX power sequencer: PA warm-up, fire_burst handshake, linear I/Q amplitude
// ramp-up/ramp-down and two's-complement to offset-binary DAC conversion.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   request_burst         burst request, accepted only while ready=1
//   ready                 high while idle
//   fire_burst            one-clock pulse to the burst controller
//   sample_strobe         sample-rate enable for the DAC registers
//   iq_valid              burst controller I/Q valid
//   inphase_in            signed I sample
//   quadrature_in         signed Q sample
//   dac_i, dac_q          offset-binary DAC codes
//   pa_enable             PA / TX-chain power enable
//   timeout_err           sticky, set when I/Q never arrives after fire_burst
module tx_ramp_sequencer #(
    parameter int WIDTH          = 6,
    parameter int DAC_MID        = 31,
    parameter int RAMP_LOG2      = 4,
    parameter int WARMUP_CYCLES  = 64,
    parameter int HOLDOFF_CYCLES = 32,
    parameter int IQ_TIMEOUT     = 256
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             request_burst,
    output logic             ready,
    output logic             fire_burst,
    input  logic             sample_strobe,
    input  logic             iq_valid,
    input  logic [WIDTH-1:0] inphase_in,
    input  logic [WIDTH-1:0] quadrature_in,
    output logic [WIDTH-1:0] dac_i,
    output logic [WIDTH-1:0] dac_q,
    output logic             pa_enable,
    output logic             timeout_err
);

    localparam int KW       = RAMP_LOG2 + 1;
    localparam int PW       = WIDTH + RAMP_LOG2 + 1;
    localparam int RAMP_LEN = 1 << RAMP_LOG2;

    localparam int MAX_A   = (WARMUP_CYCLES > HOLDOFF_CYCLES) ?
                             WARMUP_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_CNT = (MAX_A > IQ_TIMEOUT) ? MAX_A : IQ_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] IQ_LAST   = CW'(IQ_TIMEOUT - 1);

    localparam logic [WIDTH-1:0] MID_CODE = WIDTH'(DAC_MID);
    localparam logic [KW-1:0]    K_FULL   = KW'(RAMP_LEN);
    localparam logic [KW-1:0]    K_ONE    = KW'(1);

    localparam logic signed [PW-1:0] MID_S = PW'(DAC_MID);
    localparam logic signed [PW-1:0] MAX_S = PW'((1 << WIDTH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_WAIT_IQ,
        S_RAMP_UP,
        S_ACTIVE,
        S_RAMP_DOWN,
        S_HOLDOFF
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nxt;
    logic [WIDTH-1:0] hold_i;
    logic [WIDTH-1:0] hold_i_nxt;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_q_nxt;
    logic [WIDTH-1:0] dac_i_nxt;
    logic [WIDTH-1:0] dac_q_nxt;
    logic             ready_nxt;
    logic             fire_nxt;
    logic             pa_nxt;
    logic             terr_nxt;

    logic             load;
    logic             in_ramp;
    logic [KW-1:0]    gain;
    logic [WIDTH-1:0] src_i;
    logic [WIDTH-1:0] src_q;

    // Gain-scale a signed sample by g/2**RAMP_LOG2 (floor), add the DAC
    // mid-code and clamp to the DAC range.
    function automatic logic [WIDTH-1:0] scale(
        input logic [WIDTH-1:0] s,
        input logic [KW-1:0]    g
    );
        logic signed [PW-1:0] se;
        logic signed [PW-1:0] ge;
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] sc;
        logic signed [PW-1:0] c;
        se = {{(PW-WIDTH){s[WIDTH-1]}}, s};
        ge = {{(PW-KW){1'b0}}, g};
        p  = se * ge;
        sc = p >>> RAMP_LOG2;
        c  = sc + MID_S;
        if (c[PW-1]) begin
            scale = '0;
        end else if (c > MAX_S) begin
            scale = MAX_S[WIDTH-1:0];
        end else begin
            scale = c[WIDTH-1:0];
        end
    endfunction

    assign in_ramp = (state == S_RAMP_UP) ||
                     (state == S_ACTIVE)  ||
                     (state == S_RAMP_DOWN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            k           <= '0;
            hold_i      <= '0;
            hold_q      <= '0;
            dac_i       <= MID_CODE;
            dac_q       <= MID_CODE;
            ready       <= 1'b1;
            fire_burst  <= 1'b0;
            pa_enable   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            k           <= k_nxt;
            hold_i      <= hold_i_nxt;
            hold_q      <= hold_q_nxt;
            dac_i       <= dac_i_nxt;
            dac_q       <= dac_q_nxt;
            ready       <= ready_nxt;
            fire_burst  <= fire_nxt;
            pa_enable   <= pa_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        hold_i_nxt = hold_i;
        hold_q_nxt = hold_q;
        dac_i_nxt  = dac_i;
        dac_q_nxt  = dac_q;
        ready_nxt  = ready;
        fire_nxt   = 1'b0;
        pa_nxt     = pa_enable;
        terr_nxt   = timeout_err;
        load       = 1'b0;
        gain       = '0;
        src_i      = inphase_in;
        src_q      = quadrature_in;

        unique case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                pa_nxt    = 1'b0;
                if (request_burst) begin
                    state_nxt = S_WARMUP;
                    pa_nxt    = 1'b1;
                    ready_nxt = 1'b0;
                    terr_nxt  = 1'b0;
                end
            end
            S_WARMUP: begin
                if (cnt == WARM_LAST) begin
                    state_nxt = S_WAIT_IQ;
                    fire_nxt  = 1'b1;
                end
            end
            S_WAIT_IQ: begin
                if (sample_strobe && iq_valid) begin
                    state_nxt  = S_RAMP_UP;
                    load       = 1'b1;
                    gain       = K_ONE;
                    k_nxt      = K_ONE;
                    hold_i_nxt = inphase_in;
                    hold_q_nxt = quadrature_in;
                end else if (cnt == IQ_LAST) begin
                    state_nxt = S_HOLDOFF;
                    terr_nxt  = 1'b1;
                end
            end
            S_RAMP_UP, S_ACTIVE: begin
                if (sample_strobe) begin
                    load = 1'b1;
                    if (iq_valid) begin
                        // k stays pinned at unity once the ramp is done
                        gain       = (k == K_FULL) ? k : k + 1'b1;
                        k_nxt      = gain;
                        hold_i_nxt = inphase_in;
                        hold_q_nxt = quadrature_in;
                        if (gain == K_FULL) begin
                            state_nxt = S_ACTIVE;
                        end
                    end else begin
                        // stream ended: replay the last valid sample
                        src_i = hold_i;
                        src_q = hold_q;
                        gain  = k - 1'b1;
                        k_nxt = gain;
                        state_nxt = (gain == '0) ? S_HOLDOFF : S_RAMP_DOWN;
                    end
                end
            end
            S_RAMP_DOWN: begin
                if (sample_strobe) begin
                    load  = 1'b1;
                    src_i = hold_i;
                    src_q = hold_q;
                    gain  = k - 1'b1;
                    k_nxt = gain;
                    if (gain == '0) begin
                        state_nxt = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                    pa_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (load) begin
            dac_i_nxt = scale(src_i, gain);
            dac_q_nxt = scale(src_q, gain);
        end else if (!in_ramp) begin
            dac_i_nxt = MID_CODE;
            dac_q_nxt = MID_CODE;
        end

        // cycle counter restarts on every state change
        cnt_nxt = (state_nxt != state) ? '0 : cnt + 1'b1;
    end

endmodule

// File: tb/tb_tx_ramp_sequencer.sv
// Self-checking bench for tx_ramp_sequencer: vector table plus scoreboard
// for the ramp, hand sequences for warm-up, holdoff, timeout and reset.
module tb_tx_ramp_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       request_burst;
    logic       ready;
    logic       fire_burst;
    logic       sample_strobe;
    logic       iq_valid;
    logic [5:0] inphase_in;
    logic [5:0] quadrature_in;
    logic [5:0] dac_i;
    logic [5:0] dac_q;
    logic       pa_enable;
    logic       timeout_err;

    tx_ramp_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .request_burst (request_burst),
        .ready         (ready),
        .fire_burst    (fire_burst),
        .sample_strobe (sample_strobe),
        .iq_valid      (iq_valid),
        .inphase_in    (inphase_in),
        .quadrature_in (quadrature_in),
        .dac_i         (dac_i),
        .dac_q         (dac_q),
        .pa_enable     (pa_enable),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ei;
        int eq;
    } exp_t;

    typedef struct {
        bit valid;
        int i;
        int q;
        int ei;
        int eq;
    } vec_t;

    exp_t sb[$];
    vec_t tbl [0:39];
    int   n_vec;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_code(input int s, input int k);
        int p;
        int f;
        p = s * k;
        if (p >= 0) f = p / 16;
        else        f = -((-p + 15) / 16);
        f = f + 31;
        if (f < 0)  f = 0;
        if (f > 63) f = 63;
        return f;
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(63)) - 32;
    endfunction

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_i"}, int'(dac_i), e.ei);
            chk({name, "_q"}, int'(dac_q), e.eq);
        end
    endtask

    // one strobe cycle, optionally followed by an idle cycle that must hold
    task automatic strobe_cycle(input string name, input bit v,
                                input int i, input int q,
                                input int ei, input int eq,
                                input bit gap);
        sample_strobe = 1'b1;
        iq_valid      = v;
        inphase_in    = 6'(i);
        quadrature_in = 6'(q);
        sb.push_back('{ei, eq});
        tick();
        pop_cmp(name);
        if (gap) begin
            sample_strobe = 1'b0;
            iq_valid      = 1'($urandom_range(1));
            inphase_in    = 6'($urandom);
            quadrature_in = 6'($urandom);
            sb.push_back('{ei, eq});
            tick();
            pop_cmp({name, "_hold"});
        end
        sample_strobe = 1'b0;
        iq_valid      = 1'b0;
    endtask

    task automatic wait_fire(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fire_burst && n < 200);
    endtask

    int  n;
    int  j;
    int  first_fire;
    int  pulses;
    int  ready_bad;
    int  pa_bad;
    int  dac_bad;
    int  si;
    int  sq;

    initial begin
        reset_n       = 1'b0;
        request_burst = 1'b0;
        sample_strobe = 1'b0;
        iq_valid      = 1'b0;
        inphase_in    = '0;
        quadrature_in = '0;
        #12;
        chk("rst_ready", int'(ready), 1);
        chk("rst_pa", int'(pa_enable), 0);
        chk("rst_fire", int'(fire_burst), 0);
        chk("rst_terr", int'(timeout_err), 0);
        chk("rst_dac_i", int'(dac_i), 31);
        chk("rst_dac_q", int'(dac_q), 31);
        reset_n = 1'b1;
        tick();
        tick();

        // warm-up: request pulse, fire exactly at clock 65
        request_burst = 1'b1;
        tick();
        request_burst = 1'b0;
        chk("req_pa", int'(pa_enable), 1);
        chk("req_ready", int'(ready), 0);
        first_fire = -1;
        pulses     = 0;
        ready_bad  = 0;
        pa_bad     = 0;
        for (int t = 2; t <= 66; t++) begin
            tick();
            if (fire_burst) begin
                pulses++;
                if (first_fire < 0) first_fire = t;
            end
            if (ready) ready_bad++;
            if (!pa_enable) pa_bad++;
        end
        chk("fire_clk", first_fire, 65);
        chk("fire_pulses", pulses, 1);
        chk("warm_ready_low", ready_bad, 0);
        chk("warm_pa_high", pa_bad, 0);

        // ramp-up with I=+31, Q=-32, then active, then ramp-down from 16/-16
        n_vec = 0;
        for (int k = 1; k <= 16; k++) begin
            tbl[n_vec] = '{1'b1, 31, -32,
                           (k == 16) ? 62 : 30 + 2 * k,
                           (k == 16) ? 0  : 31 - 2 * k};
            n_vec++;
        end
        tbl[n_vec] = '{1'b1, 16, -16, 47, 15};
        n_vec++;
        tbl[n_vec] = '{1'b1, 16, -16, 47, 15};
        n_vec++;
        for (int k = 15; k >= 0; k--) begin
            tbl[n_vec] = '{(k == 8), rnd_s(), rnd_s(), 31 + k, 31 - k};
            n_vec++;
        end
        for (int r = 0; r < n_vec; r++) begin
            if (r == 18) request_burst = 1'b1;
            strobe_cycle($sformatf("vec%0d", r), tbl[r].valid,
                         tbl[r].i, tbl[r].q, tbl[r].ei, tbl[r].eq,
                         r != n_vec - 1);
        end

        // holdoff: pa stays up 32 clocks, request held high is ignored
        j         = 0;
        ready_bad = 0;
        dac_bad   = 0;
        do begin
            tick();
            j++;
            if (pa_enable && ready) ready_bad++;
            if (dac_i != 6'd31 || dac_q != 6'd31) dac_bad++;
        end while (pa_enable && j < 100);
        chk("holdoff_len", j, 32);
        chk("holdoff_ready", int'(ready), 1);
        chk("holdoff_ready_low", ready_bad, 0);
        chk("holdoff_dac_mid", dac_bad, 0);
        tick();
        chk("rereq_pa", int'(pa_enable), 1);
        chk("rereq_ready", int'(ready), 0);
        request_burst = 1'b0;

        // timeout: no valid I/Q after fire_burst
        wait_fire(n);
        chk("warm2_len", n, 64);
        j       = 0;
        dac_bad = 0;
        do begin
            sample_strobe = 1'($urandom_range(1));
            iq_valid      = 1'b0;
            inphase_in    = 6'($urandom);
            quadrature_in = 6'($urandom);
            tick();
            j++;
            if (dac_i != 6'd31 || dac_q != 6'd31) dac_bad++;
        end while (!timeout_err && j < 400);
        chk("timeout_len", j, 256);
        chk("timeout_dac_mid", dac_bad, 0);
        j       = 0;
        dac_bad = 0;
        do begin
            sample_strobe = 1'($urandom_range(1));
            iq_valid      = 1'b1;
            inphase_in    = 6'($urandom);
            quadrature_in = 6'($urandom);
            tick();
            j++;
            if (dac_i != 6'd31 || dac_q != 6'd31) dac_bad++;
        end while (pa_enable && j < 100);
        sample_strobe = 1'b0;
        iq_valid      = 1'b0;
        chk("to_holdoff_len", j, 32);
        chk("to_holdoff_dac_mid", dac_bad, 0);
        chk("to_sticky", int'(timeout_err), 1);
        chk("to_ready", int'(ready), 1);
        request_burst = 1'b1;
        tick();
        request_burst = 1'b0;
        chk("to_cleared", int'(timeout_err), 0);
        chk("to_req_pa", int'(pa_enable), 1);

        // random-sample ramp into ACTIVE, then reset mid-burst
        wait_fire(n);
        chk("warm3_len", n, 64);
        si = rnd_s();
        sq = rnd_s();
        for (int k = 1; k <= 16; k++) begin
            strobe_cycle($sformatf("rnd_up%0d", k), 1'b1, si, sq,
                         ref_code(si, k), ref_code(sq, k), 1'b1);
        end
        for (int r = 0; r < 3; r++) begin
            si = rnd_s();
            sq = rnd_s();
            strobe_cycle($sformatf("rnd_act%0d", r), 1'b1, si, sq,
                         ref_code(si, 16), ref_code(sq, 16), 1'b1);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_pa", int'(pa_enable), 0);
        chk("arst_ready", int'(ready), 1);
        chk("arst_dac_i", int'(dac_i), 31);
        chk("arst_dac_q", int'(dac_q), 31);
        #2;
        reset_n = 1'b1;
        pulses  = 0;
        pa_bad  = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (fire_burst) pulses++;
            if (pa_enable || !ready) pa_bad++;
        end
        chk("arst_no_fire", pulses, 0);
        chk("arst_idle", pa_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
